sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Serial-in, parallel-out front end that assembles a WIDTH-bit word from a serial bit stream.
- Presents each completed word on a parallel bus with a valid/ready handshake, feeding the downstream 4-bit parallel-load register stage.
- A one-word output slot plus a hold state absorbs downstream stalls; the serial side is back-pressured rather than dropping data.

Parameters:
- WIDTH, 4, bits per assembled word (>=2).
- MSB_FIRST, 1, 1: the first serial bit lands in pout[WIDTH-1]; 0: the first bit lands in pout[0].

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous clear of the partial or held word.
- sin, input, 1, serial data bit.
- sin_valid, input, 1, sin is valid this cycle.
- sin_ready, output, 1, the block accepts sin this cycle.
- pout, output, WIDTH, assembled parallel word.
- pout_valid, output, 1, pout holds an unconsumed word.
- pout_ready, input, 1, downstream accepts pout this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): state=FILL, bit count=0, shift register=0, pout=0, pout_valid=0, sin_ready=1 (combinational: high whenever state is FILL).
- Accept: bit accepted when sin_valid && sin_ready. Output consumed when pout_valid && pout_ready.
- Shift: MSB_FIRST=1 gives sr <= {sr[WIDTH-2:0], sin}; MSB_FIRST=0 gives sr <= {sin, sr[WIDTH-1:1]}.
- Count: bit count width is $clog2(WIDTH+1).
- FILL state:
  - An accepted bit with count<WIDTH-1 shifts in and increments count.
  - An accepted bit with count==WIDTH-1 completes the word (assembled = the shifted value including this bit).
  - If the slot is free (!pout_valid || pout_ready): load pout with the word, set pout_valid=1, count=0, stay in FILL.
  - Otherwise: latch the word in sr, go to HOLD.
- HOLD state:
  - sin_ready=0.
  - On consume, pout <= sr, pout_valid stays 1, count=0, go to FILL.
- Output slot: consume with no new load clears pout_valid. pout is held stable while pout_valid && !pout_ready.
- Latency: last bit accepted at edge N means pout_valid=1 after edge N.
- Throughput: with pout_ready tied high, one bit per cycle sustained with no bubbles.
- clr=1:
  - count=0, state=FILL, sr=0. A held word is discarded.
  - clr wins over a simultaneous bit accept.
  - The pout slot is untouched; a consume in the same cycle still clears pout_valid.
- Simultaneous word completion and consume of the old word: the new word is loaded directly (no HOLD).
- Reset mid-word: the partial word is lost; there is no recovery.
- Bits on sin are ignored while sin_valid=0 or sin_ready=0.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 bits: WIDTH data bits, then one even-parity bit (the parity bit is not shifted into sr).
  - Word completion happens on the parity bit (count==WIDTH).
  - Extra output port pout_perr (1 bit), loaded with pout: 1 when XOR(data, parity bit)!=0. Reset value 0.
- Undefined: no pout_perr port; frame = WIDTH bits exactly as above.

Decomposition:
- Package sipo_pkg holds:
  - State typedef {FILL, HOLD}.
  - Function returning the count width.
  - Constant for frame length: WIDTH, or WIDTH+1 under SIPO_PARITY_EN.
- One sub-module: sipo_out_slot (pout/pout_valid register with load/consume, WIDTH parameter, rst_n async).

Test Plan (WIDTH=4 unless noted):
- Reset: hold rst_n=0 mid-stream, then release. pout=0, pout_valid=0, sin_ready=1, and the first new word assembles from 4 fresh bits.
- Basic MSB_FIRST=1: bits 1,0,1,1 on consecutive cycles with pout_ready=1. pout=4'b1011, pout_valid high exactly one cycle after the 4th bit. MSB_FIRST=0, same bits: pout=4'b1101.
- Back-to-back streaming: 12 bits A,5,C (MSB first) with pout_ready=1. Words 4'hA, 4'h5, 4'hC appear on consecutive 4-cycle boundaries, and sin_ready is never low.
- Back-pressure: pout_ready=0, send 8 bits (4'h3 then 4'h9).
  - pout=4'h3 is stable; after the 8th bit state is HOLD and sin_ready=0; a 9th bit driven is not accepted.
  - Raise pout_ready for one cycle: pout becomes 4'h9, pout_valid stays 1, sin_ready returns to 1.
- clr: after 2 bits, assert clr together with sin_valid. The bit is dropped. The next 4 bits 0,1,1,0 give pout=4'h6. clr asserted in HOLD discards the held word while the existing pout is kept.
- SIPO_PARITY_EN: frame 1,0,1,1,p=1 gives pout=4'hB, pout_perr=0. Frame 1,0,1,1,p=0 gives pout_perr=1.

Source files
------------

// File: rtl/sipo_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sipo_pkg
// Description : Shared types and sizing helpers for the serial-in,
//               parallel-out deserializer.
//               Build option SIPO_PARITY_EN adds a trailing even-parity bit
//               to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
package sipo_pkg;

  // Assembly FSM: FILL collects bits, HOLD parks a finished word while the
  // output slot is still occupied.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } sipo_state_e;

`ifdef SIPO_PARITY_EN
  localparam bit c_PARITY_EN = 1'b1;
`else
  localparam bit c_PARITY_EN = 1'b0;
`endif

  // Width of the bit counter for a given data width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Serial bits per frame: the data bits, plus the parity bit when enabled.
  function automatic int frame_len(input int width);
    return c_PARITY_EN ? (width + 1) : width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module      : sipo_if
// Description : Serial input and parallel output handshake bundle of the
//               deserializer. The slave modport is the deserializer side.
//               Build option SIPO_PARITY_EN adds pout_perr.
// Revision    : 1.0 - initial release
// ============================================================================
interface sipo_if #(
  parameter int WIDTH = 4
) ();

  logic             clr;
  logic             sin;
  logic             sin_valid;
  logic             sin_ready;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready;
`ifdef SIPO_PARITY_EN
  logic             pout_perr;
`endif

`ifdef SIPO_PARITY_EN
  modport master (
    output clr, sin, sin_valid, pout_ready,
    input  sin_ready, pout, pout_valid, pout_perr
  );
  modport slave (
    input  clr, sin, sin_valid, pout_ready,
    output sin_ready, pout, pout_valid, pout_perr
  );
`else
  modport master (
    output clr, sin, sin_valid, pout_ready,
    input  sin_ready, pout, pout_valid
  );
  modport slave (
    input  clr, sin, sin_valid, pout_ready,
    output sin_ready, pout, pout_valid
  );
`endif

endinterface
`default_nettype wire

// File: rtl/sipo_deserializer_out_slot.sv
`default_nettype none
// ============================================================================
// Module      : sipo_out_slot
// Description : One-word output register with valid flag. A load always
//               wins over a consume; the word stays stable until consumed.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_out_slot #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_data,
  input  wire logic             consume,
  output logic      [WIDTH-1:0] pout,
  output logic                  pout_valid
);

  logic [WIDTH-1:0] r_pout;
  logic             r_valid;

  // Slot register: load a new word, or drop the valid flag once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pout  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_pout  <= load_data;
      r_valid <= 1'b1;
    end else if (consume) begin
      r_valid <= 1'b0;
    end
  end

  assign pout       = r_pout;
  assign pout_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : sipo_deserializer
// Description : Assembles WIDTH-bit words from a serial stream and hands
//               them out through a valid/ready slot. A HOLD state parks one
//               finished word during downstream stalls and back-pressures
//               the serial side instead of dropping bits.
//               Build option SIPO_PARITY_EN: each frame carries a trailing
//               even-parity bit, checked into pout_perr.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input wire logic clk,
  input wire logic rst_n,
  sipo_if.slave    bus
);

  localparam int              c_CW     = cnt_width(WIDTH);
  localparam logic [c_CW-1:0] c_LAST   = c_CW'(frame_len(WIDTH) - 1);
  localparam int              c_SLOT_W = WIDTH + (c_PARITY_EN ? 1 : 0);

  sipo_state_e       r_state;
  logic [c_CW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_sr;

  logic [WIDTH-1:0]  w_shifted;
  logic [WIDTH-1:0]  w_word;
  logic              w_accept;
  logic              w_complete;
  logic              w_consume;
  logic              w_slot_free;
  logic              w_load;
  logic [c_SLOT_W-1:0] w_load_data;
  logic [c_SLOT_W-1:0] w_slot_q;
  logic              w_slot_valid;

`ifdef SIPO_PARITY_EN
  logic              r_hold_perr;
  logic              w_perr;
`endif

  // Shift direction decides which end of pout the first serial bit reaches.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_sr[WIDTH-2:0], bus.sin};
    end else begin : g_lsb_first
      assign w_shifted = {bus.sin, r_sr[WIDTH-1:1]};
    end
  endgenerate

`ifdef SIPO_PARITY_EN
  // The completing bit is the parity bit: data is already complete in sr.
  assign w_word = r_sr;
  assign w_perr = (^r_sr) ^ bus.sin;
`else
  assign w_word = w_shifted;
`endif

  assign bus.sin_ready = (r_state == FILL);
  assign w_accept      = bus.sin_valid && (r_state == FILL);
  assign w_complete    = w_accept && (r_cnt == c_LAST);
  assign w_consume     = w_slot_valid && bus.pout_ready;
  assign w_slot_free   = !w_slot_valid || bus.pout_ready;

  // A clear suppresses both a fresh completion and the release of a held word.
  assign w_load = !bus.clr &&
                  ((w_complete && w_slot_free) || ((r_state == HOLD) && w_consume));

`ifdef SIPO_PARITY_EN
  assign w_load_data = (r_state == HOLD) ? {r_hold_perr, r_sr} : {w_perr, w_word};
`else
  assign w_load_data = (r_state == HOLD) ? r_sr : w_word;
`endif

  // Assembly FSM: shift and count bits, park a finished word when the slot is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_sr        <= '0;
`ifdef SIPO_PARITY_EN
      r_hold_perr <= 1'b0;
`endif
    end else if (bus.clr) begin
      r_state     <= FILL;
      r_cnt       <= '0;
      r_sr        <= '0;
`ifdef SIPO_PARITY_EN
      r_hold_perr <= 1'b0;
`endif
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (w_complete) begin
              r_cnt <= '0;
              r_sr  <= w_word;
              if (!w_slot_free) begin
                r_state     <= HOLD;
`ifdef SIPO_PARITY_EN
                r_hold_perr <= w_perr;
`endif
              end
            end else begin
              r_sr  <= w_shifted;
              r_cnt <= r_cnt + c_CW'(1);
            end
          end
        end
        HOLD: begin
          if (w_consume) begin
            r_state <= FILL;
            r_cnt   <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  sipo_out_slot #(
    .WIDTH (c_SLOT_W)
  ) u_out_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load),
    .load_data  (w_load_data),
    .consume    (w_consume),
    .pout       (w_slot_q),
    .pout_valid (w_slot_valid)
  );

  assign bus.pout       = w_slot_q[WIDTH-1:0];
  assign bus.pout_valid = w_slot_valid;
`ifdef SIPO_PARITY_EN
  assign bus.pout_perr  = w_slot_q[WIDTH];
`endif

endmodule
`default_nettype wire

// File: tb/tb_sipo_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_deserializer
// Description : Drives one stimulus stream into an MSB-first and an
//               LSB-first deserializer and checks both against a frame-level
//               reference model with an expected-word queue per instance.
//               Build option SIPO_PARITY_EN adds parity frames and checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_deserializer;
  import sipo_pkg::*;

  localparam int W  = 4;
  localparam int FL = frame_len(W);

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic clr        = 1'b0;
  logic sin        = 1'b0;
  logic sin_valid  = 1'b0;
  logic pout_ready = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state per instance (0: MSB first, 1: LSB first).
  int         bits [2][$];
  logic [W:0] expq [2][$];

  always #5 clk = ~clk;

  sipo_if #(.WIDTH(W)) bus_m ();
  sipo_if #(.WIDTH(W)) bus_l ();

  assign bus_m.clr = clr;  assign bus_m.sin = sin;  assign bus_m.sin_valid = sin_valid;
  assign bus_m.pout_ready = pout_ready;
  assign bus_l.clr = clr;  assign bus_l.sin = sin;  assign bus_l.sin_valid = sin_valid;
  assign bus_l.pout_ready = pout_ready;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .bus(bus_m)
  );
  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .bus(bus_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level model: collect accepted bits, build the word from its bit
  // order rules, and track how many finished words are still outstanding
  // (slot + one parked word at most).
  task automatic model_step(input int k, input logic [W-1:0] pout, input logic pv,
                            input logic srdy, input logic perr);
    int         n0;
    logic [W-1:0] w;
    logic       p;
    string      tag;
    tag = (k == 0) ? "msb" : "lsb";
    if (!rst_n) begin
      check({tag, ".rst_pout"},  32'(pout), 32'd0);
      check({tag, ".rst_valid"}, 32'(pv),   32'd0);
      check({tag, ".rst_ready"}, 32'(srdy), 32'd1);
      bits[k].delete();
      expq[k].delete();
      return;
    end
    n0 = expq[k].size();
    check({tag, ".sin_ready"},  32'(srdy), 32'(n0 < 2));
    check({tag, ".pout_valid"}, 32'(pv),   32'(n0 > 0));
    if (n0 > 0) begin
      check({tag, ".pout"}, 32'(pout), 32'(expq[k][0][W-1:0]));
      if (FL > W) check({tag, ".pout_perr"}, 32'(perr), 32'(expq[k][0][W]));
    end
    if (n0 > 0 && pout_ready) void'(expq[k].pop_front());
    if (clr) begin
      bits[k].delete();
      if (n0 == 2) void'(expq[k].pop_back());
    end else if (sin_valid && n0 < 2) begin
      bits[k].push_back(int'(sin));
      if (bits[k].size() == FL) begin
        w = '0;
        for (int i = 0; i < W; i++) begin
          if (k == 0) w[W-1-i] = bits[k][i][0];
          else        w[i]     = bits[k][i][0];
        end
        p = 1'b0;
        if (FL > W) p = (^w) ^ bits[k][W][0];
        expq[k].push_back({p, w});
        bits[k].delete();
      end
    end
  endtask

  logic perr_m, perr_l;
`ifdef SIPO_PARITY_EN
  assign perr_m = bus_m.pout_perr;
  assign perr_l = bus_l.pout_perr;
`else
  assign perr_m = 1'b0;
  assign perr_l = 1'b0;
`endif

  // Monitor: everything is stable mid-cycle; predict the coming edge.
  always @(negedge clk) begin
    model_step(0, bus_m.pout, bus_m.pout_valid, bus_m.sin_ready, perr_m);
    model_step(1, bus_l.pout, bus_l.pout_valid, bus_l.sin_ready, perr_l);
  end

  task automatic step(input logic s, input logic v, input logic r, input logic c);
    sin = s; sin_valid = v; pout_ready = r; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r);
    for (int i = W - 1; i >= 0; i--) step(w[i], 1'b1, r, 1'b0);
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic r);
    send_word(w, r);
    if (FL > W) step(^w, 1'b1, r, 1'b0);
  endtask

  initial begin
    // Power-on reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-word, then a fresh word
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    send_frame(4'b1011, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back streaming
    send_frame(4'hA, 1'b1);
    send_frame(4'h5, 1'b1);
    send_frame(4'hC, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // Back-pressure into HOLD; extra bits refused; single-cycle release
    send_frame(4'h3, 1'b0);
    send_frame(4'h9, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);

    // clr with a simultaneous bit, then a clean word
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(4'h6, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // clr while a word is parked: held word lost, slot word kept
    send_frame(4'h3, 1'b0);
    send_frame(4'h9, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_PARITY_EN
    // Good and bad parity frames
    send_word(4'b1011, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    send_word(4'b1011, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic with stalls, clears and one reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
      end
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    repeat (4) step(1'b0, 1'b0, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
